hex_digit_scanner: RTL and testbench

Time-multiplexed digit scanner that sits directly upstream of the hex-to-seven-segment decoder. It holds a multi-digit hex value and presents one nibble at a time to the decoder input. It drives an active-low digit-enable vector at a fixed refresh rate. It also supplies a blank flag, which the top level uses to force all segments off (7'b1111111) for suppressed leading zeros.

---
 rtl/hex_digit_scanner.sv | 119 +++++++++++
 tb/tb_hex_digit_scanner.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/hex_digit_scanner.sv
// hex_digit_scanner
//   Time-multiplexed scanner that feeds one nibble at a time to a hex-to-
//   seven-segment decoder and drives the matching active-low digit enable.
//   New values are staged in a shadow register and only take effect at a
//   frame boundary (digit NUM_DIGITS-1 -> 0), so a frame never tears.
//
// Ports
//   clk          rising-edge system clock
//   rst          synchronous reset, active-high
//   value_in     value to display, digit 0 is nibble [3:0]
//   load         capture strobe for value_in (single-cycle or held)
//   blank_lz     1 = suppress leading-zero digits
//   hex          nibble of the active digit (decoder input)
//   digit_en     active-low digit enables, exactly one bit low
//   digit_blank  1 = active digit is a suppressed leading zero
//   digit_idx    index of the active digit
//   frame_done   one-cycle pulse after the scan wraps to digit 0
module hex_digit_scanner #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 50000,
  localparam int IDX_W      = $clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [3:0]              hex,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    digit_blank,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_done
);

  localparam int                VAL_W     = 4 * NUM_DIGITS;
  localparam int                CNT_W     = $clog2(REFRESH_DIV);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0]  LAST_TICK = CNT_W'(REFRESH_DIV - 1);

  logic [VAL_W-1:0] shadow;
  logic [VAL_W-1:0] disp;
  logic             pend;
  logic [CNT_W-1:0] tick_cnt;
  logic [IDX_W-1:0] idx;

  logic             tick;
  logic             wrap;
  logic [IDX_W-1:0] idx_nxt;
  logic [VAL_W-1:0] disp_nxt;

  // Nibble of digit i within v.
  function automatic logic [3:0] nibble_at(input logic [VAL_W-1:0] v,
                                           input logic [IDX_W-1:0] i);
    logic [3:0] n;
    n = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (i == IDX_W'(d)) n = v[4*d +: 4];
    end
    return n;
  endfunction

  // True when digits i..NUM_DIGITS-1 of v are all zero.
  function automatic logic upper_zero(input logic [VAL_W-1:0] v,
                                      input logic [IDX_W-1:0] i);
    logic z;
    z = 1'b1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (IDX_W'(d) >= i && v[4*d +: 4] != 4'h0) z = 1'b0;
    end
    return z;
  endfunction

  always_comb begin
    tick     = (tick_cnt == LAST_TICK);
    wrap     = tick && (idx == LAST_IDX);
    idx_nxt  = (idx == LAST_IDX) ? '0 : idx + 1'b1;
    disp_nxt = disp;
    // A load landing on the wrap edge bypasses the shadow so it is shown
    // in the frame that starts right now.
    if (wrap) begin
      if (load)      disp_nxt = value_in;
      else if (pend) disp_nxt = shadow;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow      <= '0;
      disp        <= '0;
      pend        <= 1'b0;
      tick_cnt    <= '0;
      idx         <= '0;
      hex         <= 4'h0;
      digit_en    <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
      digit_blank <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (load) shadow <= value_in;
      if (wrap)      pend <= 1'b0;
      else if (load) pend <= 1'b1;
      disp <= disp_nxt;
      // Outputs are re-registered only on a digit switch and always describe
      // the digit that becomes active on that edge.
      if (tick) begin
        tick_cnt    <= '0;
        idx         <= idx_nxt;
        hex         <= nibble_at(disp_nxt, idx_nxt);
        digit_en    <= ~(NUM_DIGITS'(1) << idx_nxt);
        digit_blank <= blank_lz && (idx_nxt != '0) && upper_zero(disp_nxt, idx_nxt);
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

  assign digit_idx = idx;

endmodule

// File: tb/tb_hex_digit_scanner.sv
// Testbench for hex_digit_scanner (8 digits, 4 cycles per digit).
// A frame-level reference model tracks edges since reset, the displayed
// value and the latest pending load; every cycle all outputs are compared.
module tb_hex_digit_scanner;

  localparam int N  = 8;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [31:0] value_in = '0;
  logic [3:0]  hex;
  logic [7:0]  digit_en;
  logic        digit_blank;
  logic [2:0]  digit_idx;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int          k;
  logic [31:0] m_disp;
  logic [31:0] m_pend;
  bit          m_have;
  int          m_idx;
  logic [3:0]  m_hex;
  bit          m_blank;
  bit          m_fd;

  typedef struct {
    logic [31:0] value;
    logic        blz;
    logic [31:0] exp_hex;
    logic [7:0]  exp_blank;
  } vec_t;

  vec_t vt[6];

  hex_digit_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .value_in(value_in), .load(load),
    .blank_lz(blank_lz), .hex(hex), .digit_en(digit_en),
    .digit_blank(digit_blank), .digit_idx(digit_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: digit = (edges / RD) mod N, value swaps at every
  // multiple of RD*N edges to the most recent load seen since the last swap.
  task automatic model_edge();
    if (rst) begin
      k = 0; m_disp = 0; m_have = 0; m_idx = 0; m_hex = 0; m_blank = 0; m_fd = 0;
    end else begin
      k++;
      m_fd = 0;
      if (load) begin m_pend = value_in; m_have = 1; end
      if (k % (RD * N) == 0) begin
        m_fd = 1;
        if (m_have) begin m_disp = m_pend; m_have = 0; end
      end
      if (k % RD == 0) begin
        m_idx   = (k / RD) % N;
        m_hex   = 4'((m_disp >> (4 * m_idx)) & 32'hF);
        m_blank = blank_lz && (m_idx != 0) && ((m_disp >> (4 * m_idx)) == 0);
      end
    end
  endtask

  task automatic step();
    logic [7:0] en_exp;
    @(posedge clk);
    model_edge();
    #1;
    en_exp = 8'hFF ^ (8'h01 << m_idx);
    chk("model_hex", hex, m_hex);
    chk("model_digit_en", digit_en, en_exp);
    chk("model_digit_blank", digit_blank, m_blank);
    chk("model_digit_idx", digit_idx, m_idx);
    chk("model_frame_done", frame_done, m_fd);
  endtask

  task automatic wait_fd();
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (frame_done) seen = 1;
    end
    if (!seen) chk("frame_done_timeout", 0, 1);
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] eh;
    logic [7:0]  eb;
    eh = v.exp_hex;
    eb = v.exp_blank;
    blank_lz = v.blz;
    value_in = v.value;
    load = 1'b1;
    step();
    load = 1'b0;
    wait_fd();
    for (int d = 0; d < N; d++) begin
      chk("vec_idx", digit_idx, d);
      chk("vec_hex", hex, eh[4*d +: 4]);
      chk("vec_blank", digit_blank, eb[d]);
      repeat (RD) step();
    end
  endtask

  initial begin
    vt[0] = '{32'h1234_ABCD, 1'b0, 32'h1234_ABCD, 8'h00};
    vt[1] = '{32'h0000_00F0, 1'b1, 32'h0000_00F0, 8'hFC};
    vt[2] = '{32'h0000_0000, 1'b1, 32'h0000_0000, 8'hFE};
    vt[3] = '{32'h0001_0000, 1'b1, 32'h0001_0000, 8'hE0};
    vt[4] = '{32'h8000_0000, 1'b1, 32'h8000_0000, 8'h00};
    vt[5] = '{32'h0000_0000, 1'b0, 32'h0000_0000, 8'h00};

    // reset and release
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("rel_en_digit0", digit_en, 8'hFE);
    step();
    chk("rel_en_digit1", digit_en, 8'hFD);
    repeat (28) step();
    chk("rel_first_wrap", frame_done, 1);
    chk("rel_hex_zero", hex, 0);

    // mid-frame load: current frame keeps the old value (model checks it)
    repeat (5) step();
    value_in = 32'h1234_ABCD;
    load = 1'b1;
    step();
    load = 1'b0;
    repeat (6) step();
    chk("midframe_hex_old", hex, 0);
    wait_fd();
    chk("midframe_hex_new", hex, 4'hD);

    foreach (vt[i]) run_vec(vt[i]);

    // two loads in one frame: only the last is ever shown
    blank_lz = 1'b0;
    value_in = 32'h1111_1111; load = 1'b1; step(); load = 1'b0;
    repeat (5) step();
    value_in = 32'h2222_2222; load = 1'b1; step(); load = 1'b0;
    wait_fd();
    chk("double_load_hex", hex, 4'h2);

    // load exactly on the wrap edge goes straight to digit 0
    repeat (31) step();
    value_in = 32'h0000_0005; load = 1'b1;
    step();
    load = 1'b0;
    chk("wrap_load_hex", hex, 4'h5);
    chk("wrap_load_fd", frame_done, 1);

    // reset during digit 5 with a pending value
    repeat (5 * RD + 1) step();
    chk("pre_reset_idx", digit_idx, 5);
    value_in = 32'hDEAD_BEEF; load = 1'b1; step(); load = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("reset_en", digit_en, 8'hFE);
    chk("reset_hex", hex, 0);
    chk("reset_fd", frame_done, 0);
    wait_fd();
    chk("reset_pend_dropped", hex, 0);

    // held load with a counting value: last sampled value wins
    repeat (3) step();
    load = 1'b1;
    for (int i = 0; i < 10; i++) begin
      value_in = 32'h0000_0100 + i;
      step();
    end
    load = 1'b0;
    wait_fd();
    chk("held_load_hex0", hex, 4'h9);
    repeat (RD) step();
    chk("held_load_hex1", hex, 4'h0);

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      load     = ($urandom_range(0, 7) == 0);
      blank_lz = ($urandom_range(0, 3) != 0);
      value_in = $urandom;
      if ($urandom_range(0, 1) == 1) value_in = value_in >> (4 * $urandom_range(0, 7));
      step();
    end
    rst = 1'b0;
    load = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
